// File: rtl/bsg_mem_arb_pkg.sv
// Shared types for the single-port RAM arbiter.
//   bsg_mem_arb_slot_e   : per-requester read-response slot state
//   BSG_MEM_ARB_REQ_S    : macro that declares the request struct {w, addr, data}
//                          for a given data and address width
//   bsg_safe_clog2       : clog2 that never returns 0 (one-entry sizes still get 1 bit)

`ifndef BSG_MEM_ARB_PKG_SV
`define BSG_MEM_ARB_PKG_SV

`define BSG_MEM_ARB_REQ_S(width, addr_width) \
    typedef struct packed { \
        logic                  w; \
        logic [addr_width-1:0] addr; \
        logic [width-1:0]      data; \
    } bsg_mem_arb_req_s

package bsg_mem_arb_pkg;

    typedef enum logic [1:0] {
        e_slot_idle = 2'd0,
        e_slot_pend = 2'd1,
        e_slot_hold = 2'd2
    } bsg_mem_arb_slot_e;

    function automatic int bsg_safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`endif

// File: rtl/bsg_mem_arb_rr_picker.sv
// Round-robin one-hot picker.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   reqs             : per-requester request (already qualified by eligibility)
//   accept           : when high, a produced grant advances the pointer
//   grant            : one-hot (or zero) grant
// The pointer resets to num_req_p-1 so the search after reset begins at requester 0.

module bsg_mem_arb_rr_picker
    import bsg_mem_arb_pkg::*;
#(
    parameter int num_req_p = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [num_req_p-1:0] reqs,
    input  logic                 accept,
    output logic [num_req_p-1:0] grant
);

    localparam int ptr_w_lp = bsg_safe_clog2(num_req_p);

    logic [ptr_w_lp-1:0] last_grant_r;
    logic [ptr_w_lp-1:0] grant_idx;
    logic [ptr_w_lp-1:0] probe;
    logic                found;
    int                  idx;

    // Walk requesters starting one past the last winner; first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = last_grant_r;
        probe     = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= num_req_p; k++) begin
            idx = int'(last_grant_r) + k;
            if (idx >= num_req_p) idx = idx - num_req_p;
            probe = ptr_w_lp'(idx);
            if (!found && reqs[probe]) begin
                found        = 1'b1;
                grant[probe] = 1'b1;
                grant_idx    = probe;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_grant_r <= ptr_w_lp'(num_req_p - 1);
        end else if (accept && found) begin
            last_grant_r <= grant_idx;
        end
    end

endmodule

// File: rtl/bsg_mem_1rw_sync_arbiter.sv
// Shares one single-port synchronous RAM among num_req_p requesters.
//   v_i/w_i/addr_i/data_i/ready_o : per-requester request port
//   v_o/data_o/yumi_i             : per-requester read-response port
//   mem_*                         : drive/return of the external RAM
// Handshakes: a request transfers in a cycle where v_i[i] & ready_o[i]; a read
// response transfers in a cycle where v_o[i] & yumi_i[i]. ready_o may depend on
// v_i and yumi_i combinationally; yumi_i is only legal while v_o is high.
// Each requester has a slot FSM (slot_state, IDLE/PEND/HOLD) tracking one
// outstanding read; HOLD keeps data in a private register so later RAM cycles
// cannot overwrite an unconsumed response.

module bsg_mem_1rw_sync_arbiter
    import bsg_mem_arb_pkg::*;
#(
    parameter  int width_p       = 8,
    parameter  int els_p         = 16,
    parameter  int num_req_p     = 2,
    localparam int addr_width_lp = bsg_safe_clog2(els_p)
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,
    input  logic [num_req_p-1:0]                    v_i,
    input  logic [num_req_p-1:0]                    w_i,
    input  logic [num_req_p-1:0][addr_width_lp-1:0] addr_i,
    input  logic [num_req_p-1:0][width_p-1:0]       data_i,
    output logic [num_req_p-1:0]                    ready_o,
    output logic [num_req_p-1:0]                    v_o,
    output logic [num_req_p-1:0][width_p-1:0]       data_o,
    input  logic [num_req_p-1:0]                    yumi_i,
    output logic                                    mem_v_o,
    output logic                                    mem_w_o,
    output logic [addr_width_lp-1:0]                mem_addr_o,
    output logic [width_p-1:0]                      mem_data_o,
    input  logic [width_p-1:0]                      mem_data_i
);

    `BSG_MEM_ARB_REQ_S(width_p, addr_width_lp);

    bsg_mem_arb_req_s  reqs       [num_req_p];
    bsg_mem_arb_slot_e slot_state [num_req_p];
    bsg_mem_arb_slot_e slot_next  [num_req_p];
    logic [width_p-1:0] hold_r    [num_req_p];

    logic [num_req_p-1:0] eligible;
    logic [num_req_p-1:0] pick_reqs;
    logic [num_req_p-1:0] pick_grant;
    logic [num_req_p-1:0] grant;
    logic [num_req_p-1:0] rd_grant;

    // Gating with reset keeps ready_o and mem_v_o low the instant reset asserts.
    assign grant   = pick_grant & {num_req_p{reset_n_i}};
    assign ready_o = grant;

    bsg_mem_arb_rr_picker #(.num_req_p(num_req_p)) picker (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .reqs      (pick_reqs),
        .accept    (reset_n_i),
        .grant     (pick_grant)
    );

    for (genvar i = 0; i < num_req_p; i++) begin : g_slot
        assign reqs[i] = '{w: w_i[i], addr: addr_i[i], data: data_i[i]};

        // A busy slot may take a new read only in the cycle its data is consumed.
        assign eligible[i]  = (slot_state[i] == e_slot_idle) | yumi_i[i];
        assign pick_reqs[i] = v_i[i] & (w_i[i] | eligible[i]);
        assign rd_grant[i]  = grant[i] & ~w_i[i];

        always_comb begin
            slot_next[i] = slot_state[i];
            case (slot_state[i])
                e_slot_idle: if (rd_grant[i]) slot_next[i] = e_slot_pend;
                e_slot_pend,
                e_slot_hold: begin
                    if (yumi_i[i]) slot_next[i] = rd_grant[i] ? e_slot_pend : e_slot_idle;
                    else           slot_next[i] = e_slot_hold;
                end
                default:           slot_next[i] = e_slot_idle;
            endcase
        end

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                slot_state[i] <= e_slot_idle;
                hold_r[i]     <= '0;
            end else begin
                slot_state[i] <= slot_next[i];
                // RAM output is only valid for one cycle; capture it if not consumed.
                if (slot_state[i] == e_slot_pend && !yumi_i[i]) hold_r[i] <= mem_data_i;
            end
        end

        assign v_o[i]    = (slot_state[i] != e_slot_idle);
        assign data_o[i] = (slot_state[i] == e_slot_pend) ? mem_data_i : hold_r[i];
    end

    // RAM drive: grant is one-hot, so OR-ing masked fields is a mux that rests at 0.
    assign mem_v_o = |grant;

    always_comb begin
        mem_w_o    = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (grant[i]) begin
                mem_w_o    = mem_w_o    | reqs[i].w;
                mem_addr_o = mem_addr_o | reqs[i].addr;
                mem_data_o = mem_data_o | reqs[i].data;
            end
        end
    end

`ifndef SYNTHESIS
    if (num_req_p < 1) begin : g_bad_num_req
        $error("bsg_mem_1rw_sync_arbiter: num_req_p must be >= 1");
    end

    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert ((yumi_i & ~v_o) == '0)
            else $error("bsg_mem_1rw_sync_arbiter: yumi_i asserted without v_o");
        end
    end
`endif

endmodule

// File: tb/tb_bsg_mem_1rw_sync_arbiter.sv
module tb_bsg_mem_1rw_sync_arbiter;

    localparam int W = 8;
    localparam int E = 16;
    localparam int N = 2;
    localparam int A = 4;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      v_i, w_i, ready_o, v_o, yumi_i;
    logic [N-1:0][A-1:0] addr_i;
    logic [N-1:0][W-1:0] data_i, data_o;
    logic              mem_v_o, mem_w_o;
    logic [A-1:0]      mem_addr_o;
    logic [W-1:0]      mem_data_o;
    logic [W-1:0]      mem_data_i;

    int n_checks = 0;
    int n_pass   = 0;

    bsg_mem_1rw_sync_arbiter #(.width_p(W), .els_p(E), .num_req_p(N)) dut (
        .clk_i      (clk),
        .reset_n_i  (rst_n),
        .v_i        (v_i),
        .w_i        (w_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .ready_o    (ready_o),
        .v_o        (v_o),
        .data_o     (data_o),
        .yumi_i     (yumi_i),
        .mem_v_o    (mem_v_o),
        .mem_w_o    (mem_w_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port sync RAM: addr a holds a*0x11, except addr 5 = 0xA5.
    logic [W-1:0] ram [E];
    logic         ram_loaded = 1'b0;
    logic [W-1:0] rd_q = '0;
    assign mem_data_i = rd_q;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int a = 0; a < E; a++) ram[a] <= W'(a * 8'h11);
            ram[5]     <= 8'hA5;
            ram_loaded <= 1'b1;
        end else if (mem_v_o) begin
            if (mem_w_o) ram[mem_addr_o] <= mem_data_o;
            else         rd_q <= ram[mem_addr_o];
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        v_i = '0; w_i = '0; yumi_i = '0; addr_i = '0; data_i = '0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [N-1:0] exp_alt    [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [W-1:0] exp_stream [8] = '{8'h00, 8'h11, 8'h22, 8'hFF, 8'h44, 8'hA5, 8'h66, 8'h77};

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // reset state, with requests present to show ready is forced low
        @(negedge clk);
        v_i = 2'b11;
        #1;
        chk("reset_ready", ready_o, 2'b00);
        chk("reset_v_o", v_o, 2'b00);
        chk("reset_mem_v", mem_v_o, 1'b0);
        chk("reset_data_o", data_o, 16'h0000);
        v_i = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // single read of addr 5 by requester 0
        v_i = 2'b01; w_i = 2'b00; addr_i[0] = 4'd5;
        #1;
        chk("rd5_ready", ready_o, 2'b01);
        chk("rd5_mem_v", mem_v_o, 1'b1);
        chk("rd5_mem_w", mem_w_o, 1'b0);
        chk("rd5_mem_addr", mem_addr_o, 4'd5);
        tick();
        v_i = '0;
        #1;
        chk("rd5_v_o", v_o, 2'b01);
        chk("rd5_data", data_o[0], 8'hA5);
        yumi_i = 2'b01;
        tick();
        yumi_i = '0;
        #1;
        chk("rd5_idle", v_o, 2'b00);

        // both requesters write continuously: grants alternate, 0 first after reset
        pulse_reset();
        v_i = 2'b11; w_i = 2'b11;
        addr_i[0] = 4'd12; data_i[0] = 8'hC0;
        addr_i[1] = 4'd13; data_i[1] = 8'hD1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr_grant%0d", k), ready_o, exp_alt[k]);
            tick();
        end
        idle_inputs();

        // requester 1 reads addr 3 and holds it while requester 0 overwrites addr 3
        v_i = 2'b10; addr_i[1] = 4'd3;
        #1;
        chk("hold_rd_ready", ready_o, 2'b10);
        tick();
        v_i = 2'b11; w_i = 2'b01; addr_i[0] = 4'd3; data_i[0] = 8'hFF;
        #1;
        chk("hold_wr_ready", ready_o, 2'b01);
        chk("hold_wr_mem_w", mem_w_o, 1'b1);
        chk("hold_pend_data", data_o[1], 8'h33);
        tick();
        v_i = 2'b10; w_i = 2'b00;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("hold_v_o%0d", k), v_o, 2'b10);
            chk($sformatf("hold_data%0d", k), data_o[1], 8'h33);
            chk($sformatf("hold_blocked%0d", k), ready_o, 2'b00);
            tick();
        end
        yumi_i = 2'b10;
        #1;
        chk("hold_yumi_regrant", ready_o, 2'b10);
        tick();
        v_i = '0; yumi_i = '0;
        #1;
        chk("hold_new_v_o", v_o, 2'b10);
        chk("hold_new_data", data_o[1], 8'hFF);
        yumi_i = 2'b10;
        tick();
        yumi_i = '0;
        #1;
        chk("hold_done", v_o, 2'b00);

        // requester 0 streams reads of 0..7 with yumi every cycle
        for (int k = 0; k < 8; k++) begin
            v_i = 2'b01; addr_i[0] = A'(k); yumi_i = (k > 0) ? 2'b01 : 2'b00;
            #1;
            chk($sformatf("stream_ready%0d", k), ready_o, 2'b01);
            if (k > 0) chk($sformatf("stream_data%0d", k - 1), data_o[0], exp_stream[k - 1]);
            tick();
        end
        v_i = '0; yumi_i = 2'b01;
        #1;
        chk("stream_v_o7", v_o, 2'b01);
        chk("stream_data7", data_o[0], exp_stream[7]);
        tick();
        yumi_i = '0;
        #1;
        chk("stream_done", v_o, 2'b00);

        // reset pulse right after a read grant discards the read
        v_i = 2'b01; addr_i[0] = 4'd5;
        #1;
        chk("rst_rd_ready", ready_o, 2'b01);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_v_o_async", v_o, 2'b00);
        chk("rst_ready_async", ready_o, 2'b00);
        chk("rst_mem_v_async", mem_v_o, 1'b0);
        v_i = '0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_rel_v_o", v_o, 2'b00);
        chk("rst_rel_data", data_o[0], 8'h00);
        tick();
        chk("rst_no_stale", v_o, 2'b00);

        // write 0x5A to addr 9 by requester 1, then read it back via requester 0
        v_i = 2'b10; w_i = 2'b10; addr_i[1] = 4'd9; data_i[1] = 8'h5A;
        #1;
        chk("wr9_ready", ready_o, 2'b10);
        chk("wr9_mem_w", mem_w_o, 1'b1);
        chk("wr9_mem_addr", mem_addr_o, 4'd9);
        chk("wr9_mem_data", mem_data_o, 8'h5A);
        tick();
        v_i = 2'b01; w_i = 2'b00; addr_i[0] = 4'd9;
        #1;
        chk("rd9_ready", ready_o, 2'b01);
        chk("rd9_mem_w", mem_w_o, 1'b0);
        tick();
        v_i = '0;
        #1;
        chk("rd9_v_o", v_o, 2'b01);
        chk("rd9_data", data_o[0], 8'h5A);
        yumi_i = 2'b01;
        tick();
        yumi_i = '0;
        #1;
        chk("rd9_idle", v_o, 2'b00);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
